// File: rtl/pwm_pkg.sv
// Types and limits shared by the duty ramp controller, the PWM generator and their benches.
package pwm_pkg;

    typedef logic [7:0] duty_t;

    localparam int MAX_DUTY = 100;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN,
        ESTOP
    } ramp_state_t;

    // Clamp a requested duty to the given ceiling.
    function automatic duty_t sat_duty(input duty_t req, input duty_t limit);
        return (req > limit) ? limit : req;
    endfunction

endpackage

// File: rtl/update_tick_gen.sv
// Free-running divider: one-clock tick pulse every UPDATE_CLKS clocks (one PWM period).
module update_tick_gen #(
    parameter int UPDATE_CLKS = 50
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (UPDATE_CLKS > 1) ? $clog2(UPDATE_CLKS) : 1;
    localparam logic [CW-1:0] LAST = CW'(UPDATE_CLKS - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end

    assign tick = (count_q == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/duty_ramp_controller.sv
// Slew-limited duty command for the PWM generator: steps toward the target once per tick,
// with an emergency stop that zeroes duty and target immediately.
module duty_ramp_controller #(
    parameter int UPDATE_CLKS = 50,
    parameter int STEP        = 10,
    parameter int MAX_DUTY    = pwm_pkg::MAX_DUTY
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] target_duty,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       estop,
    output logic [7:0] DUTY_CYCLE,
    output logic       at_target,
    output logic       ramping
);

    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [7:0] STEP8 = 8'(STEP);
    localparam logic [7:0] LIMIT = 8'(MAX_DUTY);

    pwm_pkg::ramp_state_t state_q;
    pwm_pkg::ramp_state_t state_d;
    pwm_pkg::duty_t       duty_q;
    pwm_pkg::duty_t       duty_d;
    pwm_pkg::duty_t       target_q;
    pwm_pkg::duty_t       target_d;

    logic       tick;
    logic       accept;
    logic [8:0] up_sum;
    logic [7:0] down_gap;

    update_tick_gen #(
        .UPDATE_CLKS(UPDATE_CLKS)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    always_comb begin
        accept   = cmd_valid & cmd_ready & ~estop;
        up_sum   = {1'b0, duty_q} + STEP9;
        down_gap = duty_q - target_q;
        duty_d   = duty_q;
        target_d = target_q;
        state_d  = state_q;

        if (estop) begin
            duty_d   = '0;
            target_d = '0;
            state_d  = pwm_pkg::ESTOP;
        end else begin
            // A tick steps toward the target held before this edge; a command landing on
            // the same edge only takes effect from the following tick.
            if (tick) begin
                if (target_q > duty_q) begin
                    duty_d = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[7:0];
                end else if (target_q < duty_q) begin
                    duty_d = ({1'b0, down_gap} > STEP9) ? (duty_q - STEP8) : target_q;
                end
            end

            if (accept) begin
                target_d = pwm_pkg::sat_duty(target_duty, LIMIT);
            end

            if (target_q > duty_d) begin
                state_d = pwm_pkg::RAMP_UP;
            end else if (target_q < duty_d) begin
                state_d = pwm_pkg::RAMP_DOWN;
            end else begin
                state_d = pwm_pkg::IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= pwm_pkg::IDLE;
            duty_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            target_q <= target_d;
        end
    end

    assign DUTY_CYCLE = duty_q;
    assign cmd_ready  = (state_q != pwm_pkg::ESTOP);
    assign at_target  = (state_q == pwm_pkg::IDLE) && (duty_q == target_q);
    assign ramping    = (state_q == pwm_pkg::RAMP_UP) || (state_q == pwm_pkg::RAMP_DOWN);

endmodule
